jtkiwi_tdraw: RTL

// - Tile-row draw engine: responder end of the draw/busy command interface issued by the SETA tilemap column sequencer.
// - Accepts one command per 16-pixel tile row, fetches 2x32-bit words from tile ROM and writes 16 pixels into a 9-bit line buffer.
// - Sits between the tilemap scan logic (command side), the SDRAM ROM slot (rom_* side) and the line buffer write port (buf_* side).

---
 rtl/jtkiwi_tdraw.sv | 129 ++++++++++++
 1 files changed

// File: rtl/jtkiwi_tdraw.sv
// jtkiwi_tdraw: tile-row draw engine, fetches two ROM words per 16-pixel row and writes them to a line buffer.
// Optional JTKIWI_TDRAW_PREFETCH_EN requests the second word while the first half is drawn.
module jtkiwi_tdraw #(
  parameter int TRANSP = 1
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        draw,
  output logic        busy,
  input  logic [15:0] code,
  input  logic [15:0] attr,
  input  logic [8:0]  xpos,
  input  logic [3:0]  ysub,
  output logic [17:0] rom_addr,
  output logic        rom_cs,
  input  logic        rom_ok,
  input  logic [31:0] rom_data,
  output logic [8:0]  buf_addr,
  output logic        buf_we,
  output logic [8:0]  buf_din
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAW} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d, pix;
  logic [17:0] addr_q, addr_d;
  logic        first_q, first_d;
  logic        hflip_q;
  logic [4:0]  pal_q;
  logic [8:0]  xpos_q;
  logic [2:0]  b;
  logic [3:0]  pen;
  logic        accept, take, pf_cs;
  logic        unused;
`ifdef JTKIWI_TDRAW_PREFETCH_EN
  logic [31:0] shadow_q, shadow_d;
  logic        have_q, have_d;
`endif
  assign unused = ^{attr[10:0], code[13]};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    data_d = data_q;
    addr_d = addr_q;
`ifdef JTKIWI_TDRAW_PREFETCH_EN
    shadow_d = shadow_q;
    have_d = have_q;
    pf_cs = state_q == DRAW && !cnt_q[3] && !have_q;
`else
    pf_cs = 1'b0;
`endif
    accept = state_q == IDLE && draw;
    rom_cs = state_q == FETCH || pf_cs;
    take = rom_cs && rom_ok && !first_q;
    // a fresh address is presented whenever the request starts or a word was just taken
    first_d = !rom_cs || take;
    busy = state_q != IDLE;
    rom_addr = addr_q;
    b = hflip_q ? cnt_q[2:0] : ~cnt_q[2:0];
    pix = data_q >> b;
    pen = {pix[24], pix[16], pix[8], pix[0]};
    buf_we = state_q == DRAW && !(TRANSP != 0 && pen == 4'd0);
    buf_addr = xpos_q + {5'd0, cnt_q};
    buf_din = {pal_q, pen};
    if (accept) begin
      state_d = FETCH;
      cnt_d = 4'd0;
      addr_d = {code[12:0], code[14] ? ~ysub : ysub, code[15]};
`ifdef JTKIWI_TDRAW_PREFETCH_EN
      have_d = 1'b0;
`endif
    end
    if (state_q == FETCH && take) begin
      state_d = DRAW;
      data_d = rom_data;
      addr_d[0] = cnt_q[3] ? addr_q[0] : ~addr_q[0];
    end
    if (state_q == DRAW) begin
      cnt_d = cnt_q + 4'd1;
`ifdef JTKIWI_TDRAW_PREFETCH_EN
      if (take) begin
        shadow_d = rom_data;
        have_d = 1'b1;
      end
      if (cnt_q == 4'd7) begin
        data_d = have_q ? shadow_q : rom_data;
        state_d = have_q || take ? DRAW : FETCH;
      end
`else
      if (cnt_q == 4'd7) state_d = FETCH;
`endif
      if (cnt_q == 4'd15) state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      data_q <= 32'd0;
      addr_q <= 18'd0;
      first_q <= 1'b1;
      hflip_q <= 1'b0;
      pal_q <= 5'd0;
      xpos_q <= 9'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      addr_q <= addr_d;
      first_q <= first_d;
      if (accept) begin
        hflip_q <= code[15];
        pal_q <= attr[15:11];
        xpos_q <= xpos;
      end
    end
  end
`ifdef JTKIWI_TDRAW_PREFETCH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= 32'd0;
      have_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      have_q <= have_d;
    end
  end
`endif
endmodule
